// File: rtl/uart_block_assembler_pkg.sv
// Shared definitions for the UART block assembler and the transmitter-side response framer:
// FSM state encoding, frame command bytes and default block size.
package uart_block_assembler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [7:0] UART_CMD_KEY     = 8'h4B;
    localparam logic [7:0] UART_CMD_PT      = 8'h50;
    localparam int         UART_BLOCK_BYTES = 16;

    // True when a byte opens a key or plaintext frame.
    function automatic logic is_frame_cmd(input logic [7:0] b, input logic [7:0] key_cmd,
                                          input logic [7:0] pt_cmd);
        return (b == key_cmd) || (b == pt_cmd);
    endfunction

endpackage

// File: rtl/uart_block_assembler_if.sv
// Byte-in / block-out handshake bundle between UART receiver, assembler and cipher core.
interface uart_block_assembler_if #(
    parameter int BLOCK_BYTES = 16
);
    logic [7:0]               rx_byte;
    logic                     rx_done;
    logic [8*BLOCK_BYTES-1:0] block_data;
    logic                     block_is_key;
    logic                     block_valid;
    logic                     block_ready;

    modport slave (
        input  rx_byte, rx_done, block_ready,
        output block_data, block_is_key, block_valid
    );

    modport master (
        output rx_byte, rx_done, block_ready,
        input  block_data, block_is_key, block_valid
    );
endinterface

// File: rtl/uart_byte_timeout.sv
// Inter-byte idle counter: counts enabled cycles since the last clear and flags
// when the count has reached TIMEOUT_CYCLES-1.
module uart_byte_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int              CW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
    localparam logic [CW-1:0]   NEAR_LIMIT = CW'(TIMEOUT_CYCLES - 2);

    logic [CW-1:0] cnt_r;
    logic          expired_r;

    // Counter with clear priority; expired is registered so it rises exactly as cnt hits the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r     <= '0;
            expired_r <= 1'b0;
        end else if (clear) begin
            cnt_r     <= '0;
            expired_r <= 1'b0;
        end else if (enable) begin
            cnt_r     <= cnt_r + CNT_ONE;
            expired_r <= (cnt_r == NEAR_LIMIT);
        end else begin
            cnt_r     <= cnt_r;
            expired_r <= expired_r;
        end
    end

    assign expired = expired_r;
endmodule

// File: rtl/uart_block_assembler.sv
// Collects a command byte plus BLOCK_BYTES data bytes from the UART receiver into one
// AES block and offers it on a valid/ready handshake; bad, stalled or overrun bytes raise err_flag.
module uart_block_assembler
    import uart_block_assembler_pkg::*;
#(
    parameter int         BLOCK_BYTES    = UART_BLOCK_BYTES,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] CMD_KEY        = UART_CMD_KEY,
    parameter logic [7:0] CMD_PT         = UART_CMD_PT
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_block_assembler_if.slave  bus,
    output logic                   err_flag,
    output logic                   busy
);
    localparam int             W        = 8 * BLOCK_BYTES;
    localparam int             BCW      = $clog2(BLOCK_BYTES + 1);
    localparam logic [BCW-1:0] CNT_ONE  = BCW'(1);
    localparam logic [BCW-1:0] LAST_IDX = BCW'(BLOCK_BYTES - 1);

    state_t           state_r;
    // Holds the first BLOCK_BYTES-1 bytes; the final byte goes straight into block_data.
    logic [W-9:0]     shift_r;
    logic [BCW-1:0]   byte_cnt_r;
    logic             type_key_r;
    logic [W-1:0]     data_r;
    logic             key_r;
    logic             valid_r;
    logic             err_r;
    logic             busy_r;
    logic             tmo_clear_s;
    logic             tmo_enable_s;
    logic             tmo_expired_s;

    // Idle timer runs only inside a frame and restarts on every received byte.
    always_comb begin
        tmo_enable_s = (state_r == ST_LOAD);
        tmo_clear_s  = (state_r != ST_LOAD) || bus.rx_done;
    end

    uart_byte_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmo_clear_s),
        .enable  (tmo_enable_s),
        .expired (tmo_expired_s)
    );

    // Frame FSM with its datapath; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            shift_r    <= '0;
            byte_cnt_r <= '0;
            type_key_r <= 1'b0;
            data_r     <= '0;
            key_r      <= 1'b0;
            valid_r    <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.rx_done) begin
                        if (is_frame_cmd(bus.rx_byte, CMD_KEY, CMD_PT)) begin
                            type_key_r <= (bus.rx_byte == CMD_KEY);
                            byte_cnt_r <= '0;
                            busy_r     <= 1'b1;
                            state_r    <= ST_LOAD;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (bus.rx_done) begin
                        shift_r    <= {shift_r[W-17:0], bus.rx_byte};
                        byte_cnt_r <= byte_cnt_r + CNT_ONE;
                        if (byte_cnt_r == LAST_IDX) begin
                            data_r  <= {shift_r, bus.rx_byte};
                            key_r   <= type_key_r;
                            valid_r <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= ST_HOLD;
                        end
                    end else if (tmo_expired_s) begin
                        err_r      <= 1'b1;
                        busy_r     <= 1'b0;
                        shift_r    <= '0;
                        byte_cnt_r <= '0;
                        state_r    <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    // Any byte arriving while a block is pending is an overrun; the block stays intact.
                    if (bus.rx_done) begin
                        err_r <= 1'b1;
                    end
                    if (bus.block_ready) begin
                        valid_r <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.block_data   = data_r;
    assign bus.block_is_key = key_r;
    assign bus.block_valid  = valid_r;
    assign err_flag         = err_r;
    assign busy             = busy_r;
endmodule

// File: tb/tb_uart_block_assembler.sv
// Directed-plus-random bench for uart_block_assembler; expected blocks are built from byte queues.
module tb_uart_block_assembler;
    localparam int BB  = 16;
    localparam int TMO = 100;
    localparam int W   = 8 * BB;
    localparam logic [7:0] C_KEY = 8'h4B;
    localparam logic [7:0] C_PT  = 8'h50;

    logic clk = 1'b0;
    logic reset;
    logic err_flag;
    logic busy;

    int checks     = 0;
    int errors     = 0;
    int err_pulses = 0;
    int accepts    = 0;

    uart_block_assembler_if #(.BLOCK_BYTES(BB)) bus ();

    uart_block_assembler #(
        .BLOCK_BYTES    (BB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .err_flag (err_flag),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Independent observers of error pulses and handshake acceptances.
    always @(negedge clk) begin
        if (err_flag === 1'b1) err_pulses++;
        if (bus.block_valid === 1'b1 && bus.block_ready === 1'b1) accepts++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack_block(input logic [7:0] q[$]);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < BB; i++) r[W-1-8*i -: 8] = q[i];
        return r;
    endfunction

    task automatic make_frame(output logic [7:0] q[$]);
        q = {};
        for (int i = 0; i < BB; i++) q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_byte = b;
        bus.rx_done = 1'b1;
        tick();
        bus.rx_done = 1'b0;
        bus.rx_byte = 8'h00;
    endtask

    task automatic send_body(input logic [7:0] q[$], input int maxgap);
        for (int i = 0; i < BB; i++) begin
            send_byte(q[i]);
            if (i < BB - 1) begin
                check("busy_in_frame", busy, 1'b1);
                check("no_early_valid", bus.block_valid, 1'b0);
                repeat ($urandom_range(0, maxgap)) tick();
            end
        end
    endtask

    task automatic expect_block(input string tag, input logic [7:0] q[$], input logic is_key);
        check({tag, "_valid"}, bus.block_valid, 1'b1);
        check({tag, "_data"}, bus.block_data, pack_block(q));
        check({tag, "_is_key"}, bus.block_is_key, is_key);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic accept_after(input string tag, input logic [7:0] q[$], input int delay);
        int a0;
        a0 = accepts;
        repeat (delay) begin
            tick();
            check({tag, "_held_valid"}, bus.block_valid, 1'b1);
            check({tag, "_held_data"}, bus.block_data, pack_block(q));
        end
        bus.block_ready = 1'b1;
        tick();
        bus.block_ready = 1'b0;
        check({tag, "_valid_low"}, bus.block_valid, 1'b0);
        tick();
        check({tag, "_accepts"}, 128'(accepts - a0), 128'(1));
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] b;
        logic       k;
        int         e0;
        int         a0;

        bus.rx_byte     = 8'h00;
        bus.rx_done     = 1'b0;
        bus.block_ready = 1'b0;
        reset           = 1'b1;
        repeat (2) tick();
        check("rst_valid", bus.block_valid, 1'b0);
        check("rst_data", bus.block_data, 128'h0);
        check("rst_is_key", bus.block_is_key, 1'b0);
        check("rst_err", err_flag, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        tick();

        // 1: plaintext 00..0F with ready already high
        q = {};
        for (int i = 0; i < BB; i++) q.push_back(8'(i));
        bus.block_ready = 1'b1;
        a0 = accepts;
        send_byte(C_PT);
        send_body(q, 0);
        expect_block("t1", q, 1'b0);
        check("t1_const", bus.block_data, 128'h000102030405060708090A0B0C0D0E0F);
        tick();
        check("t1_valid_low", bus.block_valid, 1'b0);
        bus.block_ready = 1'b0;
        tick();
        check("t1_accepts", 128'(accepts - a0), 128'(1));

        // random frames with random gaps and random ready delays
        e0 = err_pulses;
        for (int f = 0; f < 8; f++) begin
            k = 1'($urandom_range(0, 1));
            make_frame(q);
            send_byte(k ? C_KEY : C_PT);
            repeat ($urandom_range(0, 3)) tick();
            send_body(q, 3);
            expect_block("rnd", q, k);
            accept_after("rnd", q, int'($urandom_range(0, 4)));
        end
        check("rnd_no_err", 128'(err_pulses - e0), 128'(0));

        // 2: key frame of A5, ready withheld for 50 cycles
        q = {};
        for (int i = 0; i < BB; i++) q.push_back(8'hA5);
        send_byte(C_KEY);
        send_body(q, 0);
        expect_block("t2", q, 1'b1);
        accept_after("t2", q, 50);
        check("t2_busy", busy, 1'b0);

        // 3: non-command bytes in IDLE
        e0 = err_pulses;
        send_byte(8'h00);
        check("t3_err", err_flag, 1'b1);
        check("t3_valid", bus.block_valid, 1'b0);
        check("t3_busy", busy, 1'b0);
        tick();
        check("t3_err_width", err_flag, 1'b0);
        for (int i = 0; i < 4; i++) begin
            do b = 8'($urandom_range(0, 255)); while (b == C_KEY || b == C_PT);
            send_byte(b);
            check("t3_rnd_err", err_flag, 1'b1);
            check("t3_rnd_busy", busy, 1'b0);
            tick();
        end
        check("t3_pulses", 128'(err_pulses - e0), 128'(5));

        // 4: partial frame then silence until timeout
        send_byte(C_PT);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)));
        repeat (TMO - 1) tick();
        check("t4_no_err_early", err_flag, 1'b0);
        check("t4_busy_early", busy, 1'b1);
        tick();
        check("t4_err", err_flag, 1'b1);
        check("t4_busy", busy, 1'b0);
        check("t4_valid", bus.block_valid, 1'b0);
        tick();
        check("t4_err_width", err_flag, 1'b0);
        make_frame(q);
        send_byte(C_KEY);
        send_body(q, 5);
        expect_block("t4k", q, 1'b1);
        accept_after("t4k", q, 2);

        // 5: overrun while block pending, including on the accept cycle
        make_frame(q);
        send_byte(C_PT);
        send_body(q, 1);
        expect_block("t5", q, 1'b0);
        e0 = err_pulses;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'($urandom_range(0, 255)));
            check("t5_err", err_flag, 1'b1);
            tick();
            check("t5_data", bus.block_data, pack_block(q));
            check("t5_valid", bus.block_valid, 1'b1);
        end
        check("t5_pulses", 128'(err_pulses - e0), 128'(3));
        bus.block_ready = 1'b1;
        send_byte(C_KEY);
        bus.block_ready = 1'b0;
        check("t5_acc_err", err_flag, 1'b1);
        check("t5_acc_valid", bus.block_valid, 1'b0);
        check("t5_acc_data", bus.block_data, pack_block(q));
        tick();
        check("t5_acc_busy", busy, 1'b0);

        // 6: reset in the middle of a frame
        send_byte(C_KEY);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(0, 255)));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_valid", bus.block_valid, 1'b0);
        check("t6_data", bus.block_data, 128'h0);
        check("t6_is_key", bus.block_is_key, 1'b0);
        check("t6_err", err_flag, 1'b0);
        check("t6_busy", busy, 1'b0);
        make_frame(q);
        send_byte(C_PT);
        send_body(q, 2);
        expect_block("t6", q, 1'b0);
        accept_after("t6", q, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
